// File: rtl/huffman_dc_decoder.sv
// Bit-serial decoder for the static DC Huffman code (prefix, magnitude, signed value).
// Define HUFFDEC_DC_DPCM_EN to add the DC predictor and output reconstructed values.
module huffman_dc_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        pred_clr,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic [10:0] dc_value,
  output logic [3:0]  dc_cat,
  output logic        dc_err
);

  typedef enum logic [1:0] {S_PFX, S_MAG, S_PAD, S_OUT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  pfx_cnt_reg;
  logic [1:0]  pfx_bits_reg;
  logic [3:0]  mag_cnt_reg;
  logic [3:0]  mag_cat_reg;
  logic [9:0]  mag_reg;
  logic [10:0] dc_value_reg;
  logic [3:0]  dc_cat_reg;
  logic        dc_err_reg;
  logic [10:0] pred_val;

  logic        take;
  logic [3:0]  pfx_cnt_next;
  logic [2:0]  pfx_shift;
  logic [3:0]  cat_res;
  logic        pfx_done;
  logic        pfx_bad;
  logic [10:0] mag_full;
  logic [3:0]  msb_sel;
  logic        msb;
  logic [10:0] ones_mask;
  logic [10:0] diff;
  logic        cat11_bad;

  assign take = bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_PFX;
    else        state_reg <= state_next;
  end

  // Prefix resolution: 2-bit cat0, 3-bit cat1..5, then runs of ones ended by a zero.
  always_comb begin
    state_next   = state_reg;
    pfx_cnt_next = pfx_cnt_reg + 4'd1;
    pfx_shift    = {pfx_bits_reg, bit_in};
    cat_res      = 4'd0;
    pfx_done     = 1'b0;
    pfx_bad      = 1'b0;
    case (state_reg)
      S_PFX: if (take) begin
        if (pfx_cnt_next == 4'd2 && pfx_shift[1:0] == 2'b00) begin
          pfx_done = 1'b1;
        end else if (pfx_cnt_next == 4'd3 && pfx_shift != 3'b111) begin
          pfx_done = 1'b1;
          cat_res  = {1'b0, pfx_shift} - 4'd1;
        end else if (pfx_cnt_next >= 4'd4 && !bit_in) begin
          pfx_done = 1'b1;
          cat_res  = pfx_cnt_next + 4'd2;
        end else if (pfx_cnt_next == 4'd9) begin
          pfx_bad = 1'b1;
        end
        if (pfx_bad)       state_next = S_OUT;
        else if (pfx_done) state_next = (cat_res == 4'd0) ? S_PAD : S_MAG;
      end
      S_MAG: if (take && mag_cnt_reg == 4'd1) state_next = S_OUT;
      S_PAD: if (take) state_next = S_OUT;
      S_OUT: if (dc_ready) state_next = S_PFX;
      default: state_next = S_PFX;
    endcase
  end

  always_comb begin
    bit_ready = (state_reg != S_OUT);
    dc_valid  = (state_reg == S_OUT);
  end

  // A clear leading magnitude bit means the one's-complement negative.
  always_comb begin
    mag_full  = {mag_reg, bit_in};
    msb_sel   = mag_cat_reg - 4'd1;
    msb       = |(mag_full & (11'd1 << msb_sel));
    ones_mask = (11'd1 << mag_cat_reg) - 11'd1;
    diff      = msb ? mag_full : (mag_full - ones_mask);
    cat11_bad = (mag_cat_reg == 4'd11) && msb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pfx_cnt_reg  <= '0;
      pfx_bits_reg <= '0;
      mag_cnt_reg  <= '0;
      mag_cat_reg  <= '0;
      mag_reg      <= '0;
      dc_value_reg <= '0;
      dc_cat_reg   <= '0;
      dc_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_PFX: if (take) begin
          pfx_cnt_reg  <= pfx_cnt_next;
          pfx_bits_reg <= pfx_shift[1:0];
          if (pfx_done) begin
            mag_cnt_reg <= cat_res;
            mag_cat_reg <= cat_res;
          end
          if (pfx_bad) begin
            dc_value_reg <= '0;
            dc_cat_reg   <= '0;
            dc_err_reg   <= 1'b1;
          end
        end
        S_MAG: if (take) begin
          mag_reg     <= mag_full[9:0];
          mag_cnt_reg <= mag_cnt_reg - 4'd1;
          if (mag_cnt_reg == 4'd1) begin
            dc_cat_reg   <= mag_cat_reg;
            dc_err_reg   <= cat11_bad;
            dc_value_reg <= cat11_bad ? 11'd0 : (pred_val + diff);
          end
        end
        S_PAD: if (take) begin
          dc_cat_reg   <= '0;
          dc_err_reg   <= 1'b0;
          dc_value_reg <= pred_val;
        end
        S_OUT: if (dc_ready) begin
          pfx_cnt_reg  <= '0;
          pfx_bits_reg <= '0;
          mag_cnt_reg  <= '0;
          mag_cat_reg  <= '0;
          mag_reg      <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef HUFFDEC_DC_DPCM_EN
  logic [10:0] pred_reg;

  // A clear wins over a same-cycle handshake update.
  always_ff @(posedge clk) begin
    if (!rst_n)                                          pred_reg <= '0;
    else if (pred_clr)                                   pred_reg <= '0;
    else if (state_reg == S_OUT && dc_ready && !dc_err_reg) pred_reg <= dc_value_reg;
  end

  assign pred_val = pred_reg;
`else
  logic unused_pred_clr;
  assign unused_pred_clr = pred_clr;
  assign pred_val        = '0;
`endif

  assign dc_value = dc_value_reg;
  assign dc_cat   = dc_cat_reg;
  assign dc_err   = dc_err_reg;

endmodule

// File: doc/huffman_dc_decoder.md
# huffman_dc_decoder

- Bit-serial decoder for the static DC Huffman code produced by the team's DC encoder. Consumes one code bit per accepted beat, MSB first.
- Resolves the category prefix, collects the magnitude bits and emits the signed 11-bit DC difference, or the reconstructed DC value when the predictor is compiled in.
- Sits in the decode path between the bitstream unpacker and the dequantizer.

## Interface
- No parameters.
- clk  input  1  clock; all logic is clocked on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- bit_in  input  1  next code bit.
- bit_valid  input  1  bit_in is valid.
- bit_ready  output  1  decoder accepts a bit this cycle.
- pred_clr  input  1  clears the DC predictor (restart marker); ignored without HUFFDEC_DC_DPCM_EN.
- dc_valid  output  1  decoded symbol available.
- dc_ready  input  1  downstream accepts the symbol.
- dc_value  output  11  signed decoded value.
- dc_cat  output  4  decoded category, 0 to 11.
- dc_err  output  1  symbol is an invalid prefix or an out-of-range cat11 value.

## Operation
- Prefix codes:
  - cat0 = 00; cat1 = 010; cat2 = 011; cat3 = 100; cat4 = 101; cat5 = 110.
  - catN for N = 6..11 = (N-3) ones followed by a zero: 1110 through 111111110.
- cat0 is followed by exactly one pad bit. The pad bit is consumed and its value is ignored; the symbol is 3 bits total.
- catK with K ≥ 1 is followed by K magnitude bits v, MSB first.
  - If v[K-1] = 1: value = +v.
  - If v[K-1] = 0: value = v − (2^K − 1), which is the one's-complement negative.
- cat11 is valid only with v[10] = 0, which gives the range −1024..−2047 truncated to 11 bits; only −1024 is reachable from the encoder.
  - cat11 with v[10] = 1 sets dc_err = 1, dc_value = 0, dc_cat = 11.
- Nine consecutive prefix ones:
  - Set dc_err = 1, dc_value = 0, dc_cat = 0.
  - No further bits are consumed for that symbol.
- States:
  - S_PFX: shift prefix bits in and track the ones count.
    - Leaves to S_PAD on cat0.
    - Leaves to S_MAG when the category resolves with K ≥ 1.
    - Leaves to S_OUT on error.
  - S_MAG: down-counter loaded with K; on each accepted bit, shift into v and decrement. Move to S_OUT when the counter reaches 1 and a bit is accepted.
  - S_PAD: one accepted bit, then move to S_OUT.
  - S_OUT: dc_valid = 1. Stay until dc_ready = 1, then go to S_PFX and clear the prefix/magnitude registers.
- bit_ready = 1 in S_PFX, S_MAG and S_PAD; bit_ready = 0 in S_OUT. A bit is consumed only when bit_valid && bit_ready.
- No bits are consumed while bit_valid = 0; state and partial registers hold.
- Reset values:
  - dc_valid = 0, dc_value = 0, dc_cat = 0, dc_err = 0, bit_ready = 1.
  - State = S_PFX; predictor = 0.
- Reset asserted mid-symbol discards all partial prefix/magnitude data. The next accepted bit is treated as the first bit of a new symbol.

## Timing
- dc_value, dc_cat and dc_err are registered and stable for the whole S_OUT dwell.
- They change only on the transition into S_OUT and on reset.
- Latency: dc_valid rises on the cycle after the last code bit is accepted.
- Throughput: at most one bit per cycle. A symbol of L bits occupies at least L + 1 cycles; the extra cycle is S_OUT with bit_ready low.
- With dc_ready held at 1, S_OUT lasts exactly one cycle.
- Backpressure: while dc_valid && !dc_ready, all outputs hold and bit_ready stays 0.
- pred_clr sampled in the same cycle as the S_OUT handshake:
  - The clear applies first.
  - The next symbol's prediction starts from 0.
  - The current output is unaffected.

## Configuration
- Macro: HUFFDEC_DC_DPCM_EN.
- Defined:
  - An 11-bit predictor register is added.
  - dc_value = predictor + decoded difference, wrapping modulo 2^11.
  - The predictor is updated to dc_value on the dc_valid && dc_ready handshake of non-error symbols.
  - pred_clr (registered in any state) zeroes the predictor.
  - Error symbols output 0 and do not update the predictor.
- Undefined: dc_value = decoded difference; pred_clr is ignored and no predictor logic exists.

## Test plan
- Stream 000, 0101, 0100 with dc_ready = 1 and no DPCM -> dc_value 0, +1, −1; dc_cat 0, 1, 1; each dc_valid pulse comes one cycle after the final bit.
- 110 01011 -> −20, cat5. Then 111111110 01111111111 -> −1024, cat11, dc_err = 0.
- 111111111 -> dc_err = 1, dc_value = 0 after exactly 9 bits consumed. The next stream 000 decodes to 0.
- Send 100 101, then hold dc_ready = 0 for 5 cycles while bit_valid = 1 -> dc_value +5 held, bit_ready = 0, no bits lost. The following 011 00 decodes to −3.
- Assert rst_n = 0 for one cycle after 4 bits of 1111110 xxxxxxxxx -> all outputs 0. The fresh 010 1 then decodes to +1.
- With HUFFDEC_DC_DPCM_EN: 100 101 then 011 00 -> 5 then 2. pulse pred_clr, then 010 1 -> 1.
